glb_tile_reader: RTL and testbench

Read-side address generator and staging buffer placed directly downstream of the global buffer (GLB). On start it walks a 2-D tile of 32-bit words in GLB: num_rows rows of num_cols words, row starts row_stride bytes apart. It drives the GLB read port (re/r_addr, 1-cycle read latency) and captures returned words into a small FIFO. The FIFO feeds the PE-array input with a valid/ready handshake.

---
 rtl/glb_tile_reader.sv | 194 +++++++++++++++++++
 tb/tb_glb_tile_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/glb_tile_reader.sv
// Small ring-buffer FIFO that stages words returned by the GLB before they go to the PE array.
// Latency: a word pushed at one edge is visible at the head in the next cycle.
// Backpressure: none internally; the caller never pushes when full and never pops when empty.
module glb_tile_reader_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_dat;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);
endmodule

// Walks a rows x cols tile of 32-bit words in the GLB and streams the words out in row-major order.
// Latency: a word appears on out_valid two cycles after its glb_re (issue, capture, visible).
// Backpressure: reads are issued only while FIFO entries plus the in-flight read leave a free slot.
module glb_tile_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  num_rows,
  input  logic [DIM_WIDTH-1:0]  num_cols,
  input  logic [DIM_WIDTH-1:0]  row_stride,
  output logic                  busy,
  output logic                  done,
  output logic                  glb_re,
  output logic [ADDR_WIDTH-1:0] glb_raddr,
  input  logic [DATA_WIDTH-1:0] glb_dout,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int TOT_W = 2 * DIM_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [DIM_WIDTH-1:0] cols;
    logic [DIM_WIDTH-1:0] stride;
  } cfg_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state, nxt;
  cfg_t                  cfg;
  logic [DIM_WIDTH-1:0]  col;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [TOT_W-1:0]      remaining;
  logic [TOT_W-1:0]      total;
  logic                  inflight;
  logic                  inflight_last;
  logic                  done_q;
  logic                  accept;
  logic                  last_issue;
  logic                  drain_done;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occ;
  logic                  fifo_empty;
  logic                  pop;
  entry_t                head;
  entry_t                push_entry;

  // start is ignored while busy, including the done cycle
  assign accept     = (state == IDLE) && start && !done_q;
  assign total      = TOT_W'(num_rows) * TOT_W'(num_cols);
  assign last_issue = (remaining == TOT_W'(1));
  assign occ        = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign drain_done = (state == DRAIN) && fifo_empty && !inflight;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state: empty tiles skip straight to DRAIN, final issue moves RUN to DRAIN
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (total == '0) ? DRAIN : RUN;
      RUN:     if (glb_re && last_issue) nxt = DRAIN;
      DRAIN:   if (drain_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs: issue only when the returning word is guaranteed a FIFO slot
  always_comb begin
    glb_re = (state == RUN) && (occ < (CW+1)'(FIFO_DEPTH));
    busy   = (state != IDLE) || done_q;
  end

  // address walk, issue countdown, in-flight tracking and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg           <= '0;
      col           <= '0;
      row_base      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      inflight      <= glb_re;
      inflight_last <= glb_re && last_issue;
      done_q        <= drain_done;
      if (accept) begin
        cfg.cols   <= num_cols;
        cfg.stride <= row_stride;
        col        <= '0;
        row_base   <= base_addr;
        remaining  <= total;
      end else if (glb_re) begin
        remaining <= remaining - TOT_W'(1);
        if (col == cfg.cols - DIM_WIDTH'(1)) begin
          col      <= '0;
          row_base <= row_base + ADDR_WIDTH'(cfg.stride);
        end else begin
          col <= col + DIM_WIDTH'(1);
        end
      end
    end
  end

  assign glb_raddr       = row_base + (ADDR_WIDTH'(col) << 2);
  assign push_entry.data = glb_dout;
  assign push_entry.last = inflight_last;
  assign pop             = out_valid && out_ready;

  glb_tile_reader_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_dat (push_entry),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign done      = done_q;
  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_last  = out_valid && head.last;
endmodule

// File: tb/tb_glb_tile_reader.sv
module tb_glb_tile_reader;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_rows;
  logic [15:0] num_cols;
  logic [15:0] row_stride;
  logic        busy;
  logic        done;
  logic        glb_re;
  logic [31:0] glb_raddr;
  logic [31:0] glb_dout;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [31:0] salt   = 32'h0;

  always #5 clk = ~clk;

  glb_tile_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .row_stride (row_stride),
    .busy       (busy),
    .done       (done),
    .glb_re     (glb_re),
    .glb_raddr  (glb_raddr),
    .glb_dout   (glb_dout),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // GLB contents: each word holds its own byte address, optionally scrambled by salt
  function automatic logic [31:0] glbval(input logic [31:0] a);
    return a ^ salt;
  endfunction

  // Runs one tile from the negedge. mode 0: ready always high, 1: random ready, 2: ready low before cycle hold0.
  // busy_start_at: cycle at which a second start (different config) is pulsed while the tile is in progress.
  task automatic run_tile(input string name, input logic [31:0] base, input int rows, input int cols,
                          input logic [15:0] stride, input int mode, input int hold0, input int busy_start_at);
    logic [31:0] exp_a[$];
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic        got_l[$];
    int n, k, re_cnt, done_cnt, busy_cnt, done_cyc, first_re, first_pop, last_pop, occ, max_occ, viol, re_early;
    bit seen, prev_stall, pend_re;
    logic [31:0] prev_d, pend_a;
    logic        prev_l;
    n = rows * cols;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        exp_a.push_back(base + 32'(r) * {16'h0, stride} + 32'(4 * c));
    base_addr = base; num_rows = 16'(rows); num_cols = 16'(cols); row_stride = stride; start = 1'b1;
    re_cnt = 0; done_cnt = 0; busy_cnt = 0; done_cyc = -1; first_re = -1; first_pop = -1; last_pop = -1;
    occ = 0; max_occ = 0; viol = 0; re_early = 0; seen = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0;
    k = 0;
    while (k < 400 && !(seen && k > done_cyc + 3)) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k >= hold0);
      endcase
      if (k == busy_start_at) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; num_rows = 16'd7; num_cols = 16'd9;
      end
      if (glb_re) begin
        got_a.push_back(glb_raddr);
        re_cnt++;
        if (first_re < 0) first_re = k;
        if (k < hold0) re_early++;
      end
      if (prev_stall && (out_data !== prev_d || out_last !== prev_l)) viol++;
      prev_stall = out_valid && !out_ready;
      prev_d = out_data; prev_l = out_last;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        if (first_pop < 0) first_pop = k;
        last_pop = k;
      end
      occ = occ + int'(glb_re) - int'(out_valid && out_ready);
      if (occ > max_occ) max_occ = occ;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (!seen) done_cyc = k;
        seen = 1;
        start = 1'b1; num_rows = 16'd3; num_cols = 16'd3;
      end
      pend_re = glb_re; pend_a = glb_raddr;
      @(posedge clk); #1;
      glb_dout = pend_re ? glbval(pend_a) : 32'h0;
      start = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({name, ":done_seen"}, 64'(seen), 64'd1);
    chk({name, ":done_pulses"}, 64'(done_cnt), 64'd1);
    chk({name, ":reads"}, 64'(re_cnt), 64'(n));
    chk({name, ":busy_cycles"}, 64'(busy_cnt), 64'(done_cyc));
    chk({name, ":occupancy_within_depth"}, 64'(max_occ <= DEPTH), 64'd1);
    chk({name, ":stall_stable"}, 64'(viol), 64'd0);
    chk({name, ":pops"}, 64'(got_d.size()), 64'(n));
    for (int i = 0; i < n && i < got_a.size(); i++)
      chk($sformatf("%s:addr[%0d]", name, i), 64'(got_a[i]), 64'(exp_a[i]));
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      chk($sformatf("%s:data[%0d]", name, i), 64'(got_d[i]), 64'(glbval(exp_a[i])));
      chk($sformatf("%s:last[%0d]", name, i), 64'(got_l[i]), 64'(i == n - 1));
    end
    if (n > 0)
      chk({name, ":done_after_last_pop"}, 64'((done_cyc - last_pop) >= 1 && (done_cyc - last_pop) <= 2), 64'd1);
    if (mode == 0 && n > 0) begin
      chk({name, ":first_issue_cycle"}, 64'(first_re), 64'd1);
      chk({name, ":issue_to_visible"}, 64'(first_pop - first_re), 64'd2);
      chk({name, ":one_word_per_cycle"}, 64'(last_pop - first_pop), 64'(n - 1));
    end
    if (mode == 2)
      chk({name, ":reads_before_release"}, 64'(re_early), 64'((n < DEPTH) ? n : DEPTH));
  endtask

  // Starts a 2x3 tile, asserts reset as the third word is popped, and checks that everything clears.
  task automatic reset_mid_tile();
    int pops, dc, k;
    bit pend_re;
    logic [31:0] pend_a;
    base_addr = 32'h200; num_rows = 16'd2; num_cols = 16'd3; row_stride = 16'h10; start = 1'b1;
    pops = 0; k = 0;
    while (pops < 3 && k < 50) begin
      out_ready = 1'b1;
      if (out_valid) pops++;
      pend_re = glb_re; pend_a = glb_raddr;
      @(posedge clk); #1;
      glb_dout = pend_re ? glbval(pend_a) : 32'h0;
      start = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("rst_mid:reached_word3", 64'(pops), 64'd3);
    rst = 1'b1; glb_dout = 32'h0;
    #1;
    chk("rst_mid:busy", 64'(busy), 64'd0);
    chk("rst_mid:done", 64'(done), 64'd0);
    chk("rst_mid:glb_re", 64'(glb_re), 64'd0);
    chk("rst_mid:glb_raddr", 64'(glb_raddr), 64'd0);
    chk("rst_mid:out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid:out_data", 64'(out_data), 64'd0);
    chk("rst_mid:out_last", 64'(out_last), 64'd0);
    dc = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dc++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || out_valid) dc++;
    end
    chk("rst_mid:quiet_after_reset", 64'(dc), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; num_cols = '0; row_stride = '0;
    glb_dout = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset:busy", 64'(busy), 64'd0);
    chk("reset:done", 64'(done), 64'd0);
    chk("reset:glb_re", 64'(glb_re), 64'd0);
    chk("reset:glb_raddr", 64'(glb_raddr), 64'd0);
    chk("reset:out_valid", 64'(out_valid), 64'd0);
    chk("reset:out_data", 64'(out_data), 64'd0);
    chk("reset:out_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_tile("basic", 32'h100, 2, 3, 16'h40, 0, 0, 3);
    run_tile("backpressure", 32'h1000, 1, 8, 16'h0, 2, 10, 5);
    run_tile("rand_ready", 32'h2000, 4, 5, 16'h20, 1, 0, 7);
    run_tile("zero_cols", 32'h3000, 3, 0, 16'h10, 0, 0, -1);
    run_tile("wrap", 32'hFFFF_FFF8, 1, 4, 16'h0, 0, 0, -1);
    reset_mid_tile();
    run_tile("after_reset", 32'h200, 2, 3, 16'h10, 0, 0, 2);
    for (int t = 0; t < 4; t++) begin
      salt = $urandom;
      run_tile($sformatf("random%0d", t), $urandom, $urandom_range(1, 3), $urandom_range(1, 6),
               16'($urandom_range(0, 65535)), 1, 0, 4);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
